// File: rtl/tetris_pkg.sv
// Playfield geometry, command encodings and engine states shared by the
// board engine and the display block.
package tetris_pkg;
  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int KIND_W  = 3;
  localparam int ROW_W   = COLS * KIND_W;
  localparam int BOARD_W = ROWS * ROW_W;
  localparam int SCORE_W = 14;

  localparam logic [KIND_W-1:0]  KIND_EMPTY = 3'd0;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = 14'd9999;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/tetris_board_engine_row_full.sv
// Combinational full-row detector: a row is full when every cell is non-empty.
// Row indices outside the playfield report not-full.
module row_full_detect
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  input  logic [4:0]         row_i,
  output logic               full_o
);

  // Decode the row index, then AND together the non-empty flags of its cells.
  always_comb begin
    full_o = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_i == 5'(r)) begin
        full_o = 1'b1;
        for (int x = 0; x < COLS; x++) begin
          if (board_i[r*ROW_W + x*KIND_W +: KIND_W] == KIND_EMPTY) begin
            full_o = 1'b0;
          end else begin
            full_o = full_o;
          end
        end
      end else begin
        full_o = full_o;
      end
    end
  end

endmodule

// File: rtl/tetris_board_engine.sv
// Playfield/score owner: single-cell writes, board clear, and a commit
// sequence that collapses full rows one edge at a time for the display.
module tetris_board_engine
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3:0]         cmd_x,
  input  logic [4:0]         cmd_y,
  input  logic [KIND_W-1:0]  cmd_kind,
  output logic [BOARD_W-1:0] tetris_board,
  output logic [SCORE_W-1:0] tetris_score,
  output logic [4:0]         lines_cleared,
  output logic               busy,
  output logic               done
);

  state_e               state_q, state_d;
  logic [4:0]           row_q, row_d;
  logic [BOARD_W-1:0]   board_q, board_d, shifted_s;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [4:0]           lines_q, lines_d;
  logic                 ready_q, busy_q, done_q;
  logic [4:0]           probe_row_s;
  logic                 full_s;
  logic                 accept_s;

  assign accept_s = cmd_valid & ready_q;

  // While shifting, probe row r-1: it lands in row r on this edge, so the
  // collapsed row is re-checked without an extra scan cycle.
  assign probe_row_s = (state_q == SHIFT) ? (row_q - 5'd1) : row_q;

  row_full_detect u_row_full (
    .board_i (board_q),
    .row_i   (probe_row_s),
    .full_o  (full_s)
  );

  // Collapsed board: rows 1..r take rows 0..r-1, row 0 empties.
  always_comb begin
    shifted_s = board_q;
    for (int y = 1; y < ROWS; y++) begin
      if (5'(y) <= row_q) begin
        shifted_s[y*ROW_W +: ROW_W] = board_q[(y-1)*ROW_W +: ROW_W];
      end else begin
        shifted_s[y*ROW_W +: ROW_W] = board_q[y*ROW_W +: ROW_W];
      end
    end
    shifted_s[0 +: ROW_W] = {ROW_W{1'b0}};
  end

  // Command decode and line-clear sequencing.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    board_d = board_q;
    score_d = score_q;
    lines_d = lines_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_WRITE: begin
              for (int y = 0; y < ROWS; y++) begin
                for (int x = 0; x < COLS; x++) begin
                  if ((cmd_y == 5'(y)) && (cmd_x == 4'(x))) begin
                    board_d[(y*COLS + x)*KIND_W +: KIND_W] = cmd_kind;
                  end else begin
                    board_d = board_d;
                  end
                end
              end
            end
            OP_CLEAR: begin
              board_d = {BOARD_W{1'b0}};
              score_d = {SCORE_W{1'b0}};
              lines_d = 5'd0;
            end
            OP_COMMIT: begin
              state_d = SCAN;
              row_d   = 5'(ROWS - 1);
              lines_d = 5'd0;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (full_s) begin
          state_d = SHIFT;
        end else if (row_q != 5'd0) begin
          row_d = row_q - 5'd1;
        end else begin
          state_d = DONE;
        end
      end
      SHIFT: begin
        board_d = shifted_s;
        lines_d = lines_q + 5'd1;
        score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : (score_q + 14'd1);
        if (full_s) begin
          state_d = SHIFT;
        end else if (row_q != 5'd0) begin
          state_d = SCAN;
          row_d   = row_q - 5'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, storage and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= 5'd0;
      board_q <= {BOARD_W{1'b0}};
      score_q <= {SCORE_W{1'b0}};
      lines_q <= 5'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      board_q <= board_d;
      score_q <= score_d;
      lines_q <= lines_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign cmd_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tetris_board  = board_q;
  assign tetris_score  = score_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_tetris_board_engine.sv
// Directed and randomized bench for tetris_board_engine against an
// array-based playfield model.
module tb_tetris_board_engine;
  import tetris_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [3:0]         cmd_x;
  logic [4:0]         cmd_y;
  logic [KIND_W-1:0]  cmd_kind;
  logic [BOARD_W-1:0] tetris_board;
  logic [SCORE_W-1:0] tetris_score;
  logic [4:0]         lines_cleared;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  tetris_board_engine dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .cmd_kind      (cmd_kind),
    .tetris_board  (tetris_board),
    .tetris_score  (tetris_score),
    .lines_cleared (lines_cleared),
    .busy          (busy),
    .done          (done)
  );

  logic [KIND_W-1:0] mb [ROWS][COLS];
  int m_score;
  int m_lines;
  int errors = 0;
  int checks = 0;

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [BOARD_W-1:0] obs, input logic [BOARD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BOARD_W-1:0] pack_model();
    logic [BOARD_W-1:0] v;
    v = {BOARD_W{1'b0}};
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        v[(y*COLS + x)*KIND_W +: KIND_W] = mb[y][x];
    return v;
  endfunction

  task automatic model_zero();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        mb[y][x] = 3'd0;
    m_score = 0;
    m_lines = 0;
  endtask

  // Remove every full row, keep the rest in order, pad the top with empties.
  task automatic model_commit(output int k);
    logic [KIND_W-1:0] nb [ROWS][COLS];
    int dst;
    bit full;
    k = 0;
    dst = ROWS - 1;
    for (int y = ROWS - 1; y >= 0; y--) begin
      full = 1'b1;
      for (int x = 0; x < COLS; x++) if (mb[y][x] == 3'd0) full = 1'b0;
      if (full) k++;
      else begin
        for (int x = 0; x < COLS; x++) nb[dst][x] = mb[y][x];
        dst--;
      end
    end
    for (int y = 0; y <= dst; y++)
      for (int x = 0; x < COLS; x++) nb[y][x] = 3'd0;
    mb = nb;
    m_score = (m_score + k > 9999) ? 9999 : m_score + k;
    m_lines = k;
  endtask

  // Present a command at a falling edge, wait for acceptance, return one
  // falling edge after the accept edge.
  task automatic send(input logic [1:0] op, input logic [3:0] x, input logic [4:0] y,
                      input logic [KIND_W-1:0] k);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_kind = k;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk_v("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (op == OP_WRITE && int'(x) < COLS && int'(y) < ROWS) mb[y][x] = k;
    else if (op == OP_CLEAR) model_zero();
  endtask

  task automatic fill_row(input int y, input bit rnd);
    for (int x = 0; x < COLS; x++)
      send(OP_WRITE, 4'(x), 5'(y), rnd ? 3'($urandom_range(1, 7)) : 3'd1);
  endtask

  task automatic commit_and_check(input string tag, input bit hold_write);
    int k;
    int cnt;
    int lat;
    model_commit(k);
    send(OP_COMMIT, 4'd0, 5'd0, 3'd0);
    cnt = 1;
    chk_v({tag, " busy"}, 32'(busy), 32'd1);
    chk_v({tag, " ready_low"}, 32'(cmd_ready), 32'd0);
    if (hold_write) begin
      cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_x = 4'd1; cmd_y = 5'd1; cmd_kind = 3'd3;
    end
    lat = 0;
    while (lat == 0 && cnt < 200) begin
      if (done === 1'b1) lat = cnt;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    chk_v({tag, " latency"}, 32'(lat), 32'(ROWS + 1 + k));
    chk_v({tag, " busy_in_done"}, 32'(busy), 32'd1);
    chk_b({tag, " board"}, tetris_board, pack_model());
    chk_v({tag, " score"}, 32'(tetris_score), 32'(m_score));
    chk_v({tag, " lines"}, 32'(lines_cleared), 32'(m_lines));
    @(negedge clk);
    chk_v({tag, " done_pulse"}, 32'(done), 32'd0);
    chk_v({tag, " ready_back"}, 32'(cmd_ready), 32'd1);
    chk_v({tag, " busy_off"}, 32'(busy), 32'd0);
    if (hold_write) begin
      chk_b({tag, " held_not_early"}, tetris_board, pack_model());
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      mb[1][1] = 3'd3;
      chk_b({tag, " held_write"}, tetris_board, pack_model());
    end
  endtask

  initial begin
    int n;
    int done_cnt;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_x = 4'd0; cmd_y = 5'd0; cmd_kind = 3'd0;
    model_zero();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk_b("rst board", tetris_board, pack_model());
    chk_v("rst score", 32'(tetris_score), 32'd0);
    chk_v("rst lines", 32'(lines_cleared), 32'd0);
    chk_v("rst busy", 32'(busy), 32'd0);
    chk_v("rst done", 32'(done), 32'd0);
    chk_v("rst ready", 32'(cmd_ready), 32'd1);

    // Single write and out-of-range write
    send(OP_WRITE, 4'd3, 5'd19, 3'd5);
    chk_v("w3_19 cell", 32'(tetris_board[(19*COLS + 3)*KIND_W +: KIND_W]), 32'd5);
    chk_b("w3_19 board", tetris_board, pack_model());
    send(OP_WRITE, 4'd10, 5'd0, 3'd7);
    chk_b("w_x10 board", tetris_board, pack_model());
    chk_v("w_x10 ready", 32'(cmd_ready), 32'd1);
    send(OP_WRITE, 4'd0, 5'd20, 3'd7);
    chk_b("w_y20 board", tetris_board, pack_model());
    send(2'b11, 4'd2, 5'd2, 3'd6);
    chk_b("reserved board", tetris_board, pack_model());

    // One full row with a marker above it
    fill_row(19, 1'b0);
    send(OP_WRITE, 4'd0, 5'd18, 3'd2);
    commit_and_check("k1", 1'b0);
    chk_v("k1 row19_cell0", 32'(tetris_board[(19*COLS)*KIND_W +: KIND_W]), 32'd2);

    // Four full rows
    for (int y = 16; y < ROWS; y++) fill_row(y, 1'b1);
    commit_and_check("k4", 1'b0);
    chk_b("k4 empty", tetris_board, {BOARD_W{1'b0}});

    // Empty board with a command held during busy
    commit_and_check("k0_hold", 1'b1);

    // Score saturation
    @(negedge clk);
    force dut.score_q = 14'd9998;
    @(posedge clk);
    @(negedge clk);
    release dut.score_q;
    m_score = 9998;
    chk_v("forced score", 32'(tetris_score), 32'd9998);
    fill_row(18, 1'b1);
    fill_row(19, 1'b1);
    commit_and_check("sat", 1'b0);
    send(OP_CLEAR, 4'd0, 5'd0, 3'd0);
    chk_v("clear score", 32'(tetris_score), 32'd0);
    chk_v("clear lines", 32'(lines_cleared), 32'd0);
    chk_b("clear board", tetris_board, pack_model());

    // Reset during the second shift of a three-row clear
    for (int y = 17; y < ROWS; y++) fill_row(y, 1'b1);
    send(OP_COMMIT, 4'd0, 5'd0, 3'd0);
    n = 0;
    while (lines_cleared != 5'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_v("mid lines1", 32'(lines_cleared), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_zero();
    chk_b("mid board", tetris_board, pack_model());
    chk_v("mid score", 32'(tetris_score), 32'd0);
    chk_v("mid lines", 32'(lines_cleared), 32'd0);
    chk_v("mid busy", 32'(busy), 32'd0);
    chk_v("mid done", 32'(done), 32'd0);
    chk_v("mid ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk_v("mid no_done", 32'(done_cnt), 32'd0);
    chk_b("mid board_after", tetris_board, pack_model());

    // Randomized writes and commits
    for (int round = 0; round < 8; round++) begin
      n = $urandom_range(15, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) fill_row($urandom_range(12, 19), 1'b1);
        else if ($urandom_range(0, 9) == 0) send(2'b11, 4'd0, 5'd0, 3'd1);
        else send(OP_WRITE, 4'($urandom_range(0, 11)), 5'($urandom_range(8, 21)),
                  3'($urandom_range(0, 7)));
      end
      chk_b("rnd pre_board", tetris_board, pack_model());
      commit_and_check("rnd", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
